// File: rtl/adc128s_pkg.sv
// Shared constants and channel decode for the ADC128S bus-functional model.
package adc128s_pkg;

    localparam int FRAME_BITS   = 16;
    localparam int CMD_ADDR_MSB = 13;
    localparam int CMD_ADDR_LSB = 11;

    typedef logic [2:0] chan_t;

    localparam chan_t CH_LD_LFT  = 3'd0;
    localparam chan_t CH_LD_RGHT = 3'd4;
    localparam chan_t CH_STEER   = 3'd5;
    localparam chan_t CH_BATT    = 3'd6;

    // Unpopulated channels read as zero.
    function automatic logic [11:0] chan_select(
        input chan_t       ch,
        input logic [11:0] ld_lft,
        input logic [11:0] ld_rght,
        input logic [11:0] steer,
        input logic [11:0] batt
    );
        logic [11:0] val;
        val = 12'h000;
        case (ch)
            CH_LD_LFT:  val = ld_lft;
            CH_LD_RGHT: val = ld_rght;
            CH_STEER:   val = steer;
            CH_BATT:    val = batt;
            default:    val = 12'h000;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/adc128s_fc_model_spi_slave_edge.sv
// SPI pin synchronizers with one extra stage on SS_n/SCLK for edge strobes.
module spi_slave_edge (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic SCLK,
    input  logic MOSI,
    output logic ss_active,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic frame_start,
    output logic frame_end,
    output logic mosi_sync
);

    logic [2:0] ss_sr;
    logic [2:0] sclk_sr;
    logic [1:0] mosi_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sr   <= 3'b111;
            sclk_sr <= 3'b000;
            mosi_sr <= 2'b00;
        end else begin
            ss_sr   <= {ss_sr[1:0], SS_n};
            sclk_sr <= {sclk_sr[1:0], SCLK};
            mosi_sr <= {mosi_sr[0], MOSI};
        end
    end

    // Strobes compare stage 2 against stage 3, so actions land 3 clk after the pin edge.
    assign ss_active   = ~ss_sr[2];
    assign frame_start = ss_sr[2] & ~ss_sr[1];
    assign frame_end   = ~ss_sr[2] & ss_sr[1];
    assign sclk_rise   = ~sclk_sr[2] & sclk_sr[1];
    assign sclk_fall   = sclk_sr[2] & ~sclk_sr[1];
    assign mosi_sync   = mosi_sr[1];

endmodule

// File: rtl/adc128s_fc_model.sv
// ADC128S SPI slave model: returns the channel addressed by the previous full frame.
module adc128s_fc_model
    import adc128s_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] ld_cell_lft,
    input  logic [11:0] ld_cell_rght,
    input  logic [11:0] steerPot,
    input  logic [11:0] batt,
    output logic        update_ch
);

    logic        ss_active;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        frame_start;
    logic        frame_end;
    logic        mosi_sync;

    logic [15:0] rx_sr;
    logic [15:0] tx_sr;
    logic [4:0]  bit_cnt;
    chan_t       ch_ptr;

    spi_slave_edge u_edge (
        .clk         (clk),
        .rst         (rst),
        .SS_n        (SS_n),
        .SCLK        (SCLK),
        .MOSI        (MOSI),
        .ss_active   (ss_active),
        .sclk_rise   (sclk_rise),
        .sclk_fall   (sclk_fall),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .mosi_sync   (mosi_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sr     <= '0;
            tx_sr     <= '0;
            bit_cnt   <= '0;
            ch_ptr    <= CH_LD_LFT;
            update_ch <= 1'b0;
        end else begin
            update_ch <= 1'b0;
            if (frame_start) begin
                tx_sr   <= {4'b0000, chan_select(ch_ptr, ld_cell_lft, ld_cell_rght, steerPot, batt)};
                bit_cnt <= '0;
            end else if (ss_active) begin
                if (sclk_rise) begin
                    rx_sr <= {rx_sr[14:0], mosi_sync};
                    // Saturate so over-long frames can never wrap back to a valid count.
                    if (bit_cnt != 5'd31) begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                if (sclk_fall) begin
                    tx_sr <= {tx_sr[14:0], 1'b0};
                end
            end
            if (frame_end && (bit_cnt == 5'(FRAME_BITS))) begin
                ch_ptr    <= rx_sr[CMD_ADDR_MSB:CMD_ADDR_LSB];
                update_ch <= 1'b1;
            end
        end
    end

    assign MISO = ss_active & tx_sr[15];

endmodule

// File: tb/tb_adc128s_fc_model.sv
// Self-checking bench: directed vector table, corner-case sequences, randomized frames vs model.
module tb_adc128s_fc_model;

    logic        clk = 1'b0;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [11:0] ld_cell_lft;
    logic [11:0] ld_cell_rght;
    logic [11:0] steerPot;
    logic [11:0] batt;
    logic        update_ch;

    int checks = 0;
    int errors = 0;
    int pulse_total = 0;
    logic [2:0] ref_ptr;

    adc128s_fc_model dut (
        .clk          (clk),
        .rst          (rst),
        .SS_n         (SS_n),
        .SCLK         (SCLK),
        .MOSI         (MOSI),
        .MISO         (MISO),
        .ld_cell_lft  (ld_cell_lft),
        .ld_cell_rght (ld_cell_rght),
        .steerPot     (steerPot),
        .batt         (batt),
        .update_ch    (update_ch)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (update_ch) pulse_total++;

    typedef struct {
        logic [15:0] cmd;
        int          nclk;
        logic [15:0] exp_word;
        int          exp_pulse;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // SCLK = clk/16: MOSI set while low, MISO read just before the rise.
    task automatic bit_cycle(input logic mbit, output logic sbit);
        MOSI = mbit;
        repeat (4) @(negedge clk);
        sbit = MISO;
        SCLK = 1'b1;
        repeat (8) @(negedge clk);
        SCLK = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_frame(input logic [15:0] cmd, input int nclk, input bit scramble,
                            output logic [31:0] got, output int pulses);
        int   p0;
        logic b;
        got = '0;
        p0  = pulse_total;
        @(negedge clk);
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            if (scramble && i == 4) begin
                ld_cell_lft  = 12'($urandom);
                ld_cell_rght = 12'($urandom);
                steerPot     = 12'($urandom);
                batt         = 12'($urandom);
            end
            bit_cycle((i < 16) ? cmd[15-i] : 1'b0, b);
            got[31-i] = b;
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (8) @(negedge clk);
        pulses = pulse_total - p0;
        check("miso_idle", {31'b0, MISO}, 32'h0);
    endtask

    task automatic frame_check(input string name, input logic [15:0] cmd, input int nclk,
                               input bit scramble, input logic [15:0] exp_word, input int exp_pulse);
        logic [31:0] got;
        logic [31:0] ones;
        logic [31:0] mask;
        int          pulses;
        ones = '1;
        mask = ~(ones >> nclk);
        do_frame(cmd, nclk, scramble, got, pulses);
        check({name, "_miso"}, got & mask, {exp_word, 16'h0000} & mask);
        check({name, "_upd"}, 32'(pulses), 32'(exp_pulse));
    endtask

    function automatic logic [15:0] model_word(input logic [2:0] ptr);
        logic [11:0] vals[8];
        for (int k = 0; k < 8; k++) vals[k] = 12'h000;
        vals[0] = ld_cell_lft;
        vals[4] = ld_cell_rght;
        vals[5] = steerPot;
        vals[6] = batt;
        return {4'h0, vals[ptr]};
    endfunction

    initial begin
        logic [15:0] exp_w;
        logic [15:0] cmd;
        int          n;
        logic        b;

        tbl[0]  = '{16'h0000, 16, 16'h0ABC, 1};
        tbl[1]  = '{16'h2000, 16, 16'h0ABC, 1};
        tbl[2]  = '{16'h0000, 16, 16'h0123, 1};
        tbl[3]  = '{16'h2800, 16, 16'h0ABC, 1};
        tbl[4]  = '{16'h0000, 16, 16'h0456, 1};
        tbl[5]  = '{16'h3000, 16, 16'h0ABC, 1};
        tbl[6]  = '{16'h0000, 16, 16'h0789, 1};
        tbl[7]  = '{16'h1000, 16, 16'h0ABC, 1};
        tbl[8]  = '{16'h0000, 16, 16'h0000, 1};
        tbl[9]  = '{16'h2000, 16, 16'h0ABC, 1};
        tbl[10] = '{16'h2800, 10, 16'h0123, 0};
        tbl[11] = '{16'hC7FF, 16, 16'h0123, 1};
        tbl[12] = '{16'h2800, 18, 16'h0ABC, 0};
        tbl[13] = '{16'h0000, 16, 16'h0ABC, 1};

        rst          = 1'b1;
        SS_n         = 1'b1;
        SCLK         = 1'b0;
        MOSI         = 1'b0;
        ld_cell_lft  = 12'hABC;
        ld_cell_rght = 12'h123;
        steerPot     = 12'h456;
        batt         = 12'h789;
        repeat (3) @(negedge clk);
        check("reset_miso", {31'b0, MISO}, 32'h0);
        check("reset_upd", {31'b0, update_ch}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            frame_check($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].nclk, 1'b0,
                        tbl[i].exp_word, tbl[i].exp_pulse);
        end

        // Batt changed between frames is seen; a mid-frame change is not.
        frame_check("addr_ch6", 16'h3000, 16, 1'b0, 16'h0ABC, 1);
        batt = 12'hFFF;
        frame_check("batt_between", 16'h3000, 16, 1'b0, 16'h0FFF, 1);
        frame_check("batt_midframe", 16'h3000, 16, 1'b1, 16'h0FFF, 1);
        exp_w = {4'h0, batt};
        frame_check("batt_after_mid", 16'h2000, 16, 1'b0, exp_w, 1);
        ld_cell_lft  = 12'hABC;
        ld_cell_rght = 12'h123;
        steerPot     = 12'h456;
        batt         = 12'h789;

        // Reset mid-frame with pointer on ch4; pointer must come back as ch0.
        @(negedge clk);
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) bit_cycle(1'b0, b);
        n = pulse_total;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_miso", {31'b0, MISO}, 32'h0);
        check("midrst_upd", {31'b0, update_ch}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) bit_cycle(1'b1, b);
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_short_upd", 32'(pulse_total - n), 32'h0);
        frame_check("after_rst", 16'h0000, 16, 1'b0, 16'h0ABC, 1);

        ref_ptr = 3'd0;
        for (int i = 0; i < 30; i++) begin
            ld_cell_lft  = 12'($urandom);
            ld_cell_rght = 12'($urandom);
            steerPot     = 12'($urandom);
            batt         = 12'($urandom);
            cmd = 16'($urandom);
            n   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 20)) : 16;
            exp_w = model_word(ref_ptr);
            frame_check($sformatf("rand%0d", i), cmd, n, ($urandom_range(0, 1) == 1),
                        exp_w, (n == 16) ? 1 : 0);
            if (n == 16) ref_ptr = cmd[13:11];
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc128s_fc_model.md
# adc128s_fc_model

Bus-functional, synthesizable model of the ADC128S 8-channel 12-bit SPI A2D converter, used as the load-cell, steering-pot and battery front end in the Segway system bench. It acts as an SPI slave to the Segway A2D interface, decodes the channel address in each 16-bit frame and, on the following frame, returns the 12-bit value of that channel taken from bench-driven inputs. All logic runs on the system clock, with SPI pins oversampled.

## Interface
- No parameters.
- `clk` in 1: system clock (50 MHz in the system bench).
- `rst` in 1: asynchronous, active-high reset.
- `SS_n` in 1: SPI slave select, active low; frames a transaction.
- `SCLK` in 1: SPI serial clock from master, idle low (mode 0).
- `MOSI` in 1: master-out data; command word, MSB first.
- `MISO` out 1: slave-out data; conversion result, MSB first.
- `ld_cell_lft` in 12: analog value for channel 0.
- `ld_cell_rght` in 12: analog value for channel 4.
- `steerPot` in 12: analog value for channel 5.
- `batt` in 12: analog value for channel 6.
- `update_ch` out 1: one-clock pulse when a complete frame has latched a new channel address.

## Operation
- Frame: SS_n low for 16 SCLK periods. MOSI is sampled on SCLK rise; MISO changes on SCLK fall.
- Command word: bits [13:11] = channel address. All other bits are ignored.
- Response word: {4'b0000, result[11:0]}.
  - `result` is the channel addressed by the previous complete frame.
  - The first frame after reset returns channel 0.
- Channel map: 0 → ld_cell_lft, 4 → ld_cell_rght, 5 → steerPot, 6 → batt. Channels 1, 2, 3 and 7 return 12'h000.
- Sampling: on the SS_n falling edge, the selected input is captured into a 16-bit TX shift register. Later input changes do not affect the frame in progress.
- Frame end (SS_n rising edge):
  - If exactly 16 rising SCLK edges were seen, latch command bits [13:11] as the new channel pointer and pulse update_ch.
  - Otherwise (short or long frame), keep the old pointer and do not pulse.
- SCLK edges while SS_n is high are ignored.
- After bit 0, extra falling edges shift out 0s.
- MISO = TX[15] while SS_n is low; MISO = 0 while SS_n is high.

## Timing
- SS_n, SCLK and MOSI each pass through a 2-flop synchronizer. A 3rd flop provides edge detection on SS_n and SCLK, so edge actions occur 3 clk after the pin edge.
- The master must hold SCLK high and low for at least 4 clk each, and keep SS_n low at least 4 clk before the first SCLK rise. The Segway master (SCLK = clk/32) satisfies this.
- MISO MSB is valid 3 clk after SS_n falls.
- Each SCLK fall shifts TX left by 1, and the new MISO is valid 3 clk after that fall.
- update_ch asserts for exactly 1 clk, 3 clk after SS_n rises.
- Reset values: channel pointer = 0, TX = 0, bit count = 0, synchronizers = idle (SS_n = 1, SCLK = 0), MISO = 0, update_ch = 0.
- Reset asserted mid-frame aborts the frame with all state at reset values. The frame in progress at reset release is treated as short.

## Structure
- Shared package `adc128s_pkg`:
  - channel address constants: CH_LD_LFT = 3'd0, CH_LD_RGHT = 3'd4, CH_STEER = 3'd5, CH_BATT = 3'd6
  - FRAME_BITS = 16
  - CMD_ADDR_MSB = 13, CMD_ADDR_LSB = 11
- Sub-module `spi_slave_edge`: synchronizers plus rise/fall/frame-start/frame-end strobes.
- Remaining logic stays in the top module: RX/TX shift registers, 5-bit saturating bit counter, channel pointer, output mux.

## Test plan
- Reset, inputs 12'hABC/12'h123/12'h456/12'h789, frame with cmd 16'h0000 → MISO word 16'h0ABC (default ch0); 1 update_ch pulse.
- Frame with cmd 16'h2000 (ch4), then cmd 16'h0000 → second frame returns 16'h0123. Likewise cmd 16'h2800 → 16'h0456 and cmd 16'h3000 → 16'h0789.
- Address ch6, then change batt to 12'hFFF between frames → next frame returns 16'h0FFF. Change batt mid-frame → value captured at SS_n fall is returned.
- Address ch2 (cmd 16'h1000) → next frame returns 16'h0000.
- Frame of 10 SCLKs with cmd ch5 → no update_ch, pointer unchanged (next frame returns previous channel).
- Assert rst mid-frame → MISO = 0, update_ch = 0; next full frame returns the ch0 value.
